// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU engine for the EX stage.
// Latches operands at start, runs 32 iterations (shift-add multiply or
// restoring divide), then holds {HI,LO} with done until EX advances.
module mult_div_unit #(
  parameter int unsigned FAST_MULT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        stall,
  input  logic [5:0]  funct,
  input  logic [31:0] operand_1,
  input  logic [31:0] operand_2,
  output logic        done,
  output logic [63:0] result,
  output logic        busy
);

  localparam int unsigned W     = 32;
  localparam int unsigned CNT_W = 5;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(W - 1);

  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_counter;
  logic             r_is_div;
  logic             r_signed;
  logic             r_sign1;
  logic             r_sign2;
  logic             r_div0;
  logic [W-1:0]     r_mag1;
  logic [W-1:0]     r_mag2;
  logic [2*W-1:0]   r_acc;
  logic [2*W-1:0]   r_result;

  logic             w_is_op;
  logic             w_op_div;
  logic             w_op_signed;
  logic             w_fast_op;
  logic [W-1:0]     w_mag1;
  logic [W-1:0]     w_mag2;
  logic [2*W-1:0]   w_ext1;
  logic [2*W-1:0]   w_ext2;
  logic [2*W-1:0]   w_fast_prod;

  logic [W:0]       w_mul_sum;
  logic [2*W-1:0]   w_mul_acc;
  logic [W:0]       w_div_shift;
  logic [W:0]       w_div_diff;
  logic             w_div_ge;
  logic [2*W-1:0]   w_div_acc;
  logic [2*W-1:0]   w_acc_nxt;

  logic             w_neg_q;
  logic [2*W-1:0]   w_mul_res;
  logic [W-1:0]     w_quo_raw;
  logic [W-1:0]     w_rem_raw;
  logic [W-1:0]     w_quo;
  logic [W-1:0]     w_rem;
  logic [2*W-1:0]   w_result_final;

  // Opcode decode: bit1 selects divide, bit0 selects unsigned.
  assign w_is_op     = (funct == F_MULT) || (funct == F_MULTU) ||
                       (funct == F_DIV)  || (funct == F_DIVU);
  assign w_op_div    = funct[1];
  assign w_op_signed = ~funct[0];
  assign w_fast_op   = (FAST_MULT != 0) && !w_op_div;

  // Magnitudes fed to the unsigned iteration core.
  assign w_mag1 = (w_op_signed && operand_1[W-1]) ? (~operand_1 + W'(1)) : operand_1;
  assign w_mag2 = (w_op_signed && operand_2[W-1]) ? (~operand_2 + W'(1)) : operand_2;

  // Single-cycle product; low 64 bits of the extended product are exact.
  assign w_ext1      = w_op_signed ? {{W{operand_1[W-1]}}, operand_1} : {{W{1'b0}}, operand_1};
  assign w_ext2      = w_op_signed ? {{W{operand_2[W-1]}}, operand_2} : {{W{1'b0}}, operand_2};
  assign w_fast_prod = w_ext1 * w_ext2;

  // Multiply step: acc = {partial_hi, multiplier_lo}; add multiplicand then shift right.
  assign w_mul_sum = {1'b0, r_acc[2*W-1:W]} + {1'b0, (r_acc[0] ? r_mag1 : {W{1'b0}})};
  assign w_mul_acc = {w_mul_sum, r_acc[W-1:1]};

  // Divide step: acc = {remainder, dividend/quotient}; 33-bit trial subtract.
  assign w_div_shift = r_acc[2*W-1:W-1];
  assign w_div_diff  = w_div_shift - {1'b0, r_mag2};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_mag2});
  assign w_div_acc   = w_div_ge ? {w_div_diff[W-1:0], r_acc[W-2:0], 1'b1}
                                : {r_acc[2*W-2:0], 1'b0};

  assign w_acc_nxt = r_is_div ? w_div_acc : w_mul_acc;

  // Sign fix-up applied only on the final iteration's write-back.
  assign w_neg_q   = r_signed & (r_sign1 ^ r_sign2);
  assign w_mul_res = w_neg_q ? (~w_acc_nxt + (2*W)'(1)) : w_acc_nxt;
  assign w_quo_raw = w_acc_nxt[W-1:0];
  assign w_rem_raw = w_acc_nxt[2*W-1:W];
  assign w_quo     = r_div0  ? {W{1'b1}} :
                     w_neg_q ? (~w_quo_raw + W'(1)) : w_quo_raw;
  assign w_rem     = (r_signed & r_sign1) ? (~w_rem_raw + W'(1)) : w_rem_raw;
  assign w_result_final = r_is_div ? {w_rem, w_quo} : w_mul_res;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; flush overrides start and the DONE release.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_op) begin
            w_state_nxt = w_fast_op ? S_DONE : S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_counter == LAST_ITER) begin
            w_state_nxt = S_DONE;
          end
        end
        S_DONE: begin
          if (!stall) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Operand capture, iteration, and result write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_counter <= '0;
      r_is_div  <= 1'b0;
      r_signed  <= 1'b0;
      r_sign1   <= 1'b0;
      r_sign2   <= 1'b0;
      r_div0    <= 1'b0;
      r_mag1    <= '0;
      r_mag2    <= '0;
      r_acc     <= '0;
      r_result  <= '0;
    end else if (!flush) begin
      case (r_state)
        S_IDLE: begin
          if (w_is_op) begin
            r_is_div  <= w_op_div;
            r_signed  <= w_op_signed;
            r_sign1   <= operand_1[W-1];
            r_sign2   <= operand_2[W-1];
            r_div0    <= (operand_2 == '0);
            r_mag1    <= w_mag1;
            r_mag2    <= w_mag2;
            r_acc     <= w_op_div ? {{W{1'b0}}, w_mag1} : {{W{1'b0}}, w_mag2};
            r_counter <= '0;
            if (w_fast_op) begin
              r_result <= w_fast_prod;
            end
          end
        end
        S_BUSY: begin
          r_acc     <= w_acc_nxt;
          r_counter <= r_counter + CNT_W'(1);
          if (r_counter == LAST_ITER) begin
            r_result <= w_result_final;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign done   = (r_state == S_DONE);
  assign busy   = (r_state == S_BUSY);
  assign result = r_result;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: iterative and FAST_MULT instances side by side,
// an arithmetic reference model checked every cycle, plus directed literals.
module tb_mult_div_unit;

  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;

  localparam int PH_IDLE = 0;
  localparam int PH_WORK = 1;
  localparam int PH_HOLD = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        stall;
  logic [5:0]  funct;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        done,   done_f;
  logic        busy,   busy_f;
  logic [63:0] result, result_f;

  int checks = 0;
  int errors = 0;

  int          m_phase [2] = '{PH_IDLE, PH_IDLE};
  int          m_left  [2] = '{0, 0};
  logic [63:0] m_res   [2] = '{64'h0, 64'h0};
  logic [63:0] m_pend  [2] = '{64'h0, 64'h0};

  mult_div_unit #(.FAST_MULT(0)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall), .funct(funct),
    .operand_1(op1), .operand_2(op2), .done(done), .result(result), .busy(busy)
  );

  mult_div_unit #(.FAST_MULT(1)) dut_fast (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall), .funct(funct),
    .operand_1(op1), .operand_2(op2), .done(done_f), .result(result_f), .busy(busy_f)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_op(input logic [5:0] f);
    return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
  endfunction

  function automatic bit is_mul(input logic [5:0] f);
    return (f == F_MULT) || (f == F_MULTU);
  endfunction

  // Architectural {HI,LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_res(input logic [5:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    longint          sa, sb, sq, sr, sp;
    longint unsigned ua, ub, uq, ur, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    if (f == F_MULT) begin
      sp = sa * sb;
      return 64'(sp);
    end
    if (f == F_MULTU) begin
      up = ua * ub;
      return up;
    end
    if (b == 32'h0) return {a, 32'hFFFFFFFF};
    if (f == F_DIV) begin
      sq = sa / sb;
      sr = sa % sb;
      return {sr[31:0], sq[31:0]};
    end
    uq = ua / ub;
    ur = ua % ub;
    return {ur[31:0], uq[31:0]};
  endfunction

  // Reference model: index 0 iterative, index 1 fast multiply.
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_phase[i] <= PH_IDLE;
        m_left[i]  <= 0;
        m_res[i]   <= 64'h0;
      end else if (flush) begin
        m_phase[i] <= PH_IDLE;
      end else begin
        case (m_phase[i])
          PH_IDLE: begin
            if (is_op(funct)) begin
              if (i == 1 && is_mul(funct)) begin
                m_res[i]   <= ref_res(funct, op1, op2);
                m_phase[i] <= PH_HOLD;
              end else begin
                m_pend[i]  <= ref_res(funct, op1, op2);
                m_left[i]  <= 32;
                m_phase[i] <= PH_WORK;
              end
            end
          end
          PH_WORK: begin
            m_left[i] <= m_left[i] - 1;
            if (m_left[i] == 1) begin
              m_res[i]   <= m_pend[i];
              m_phase[i] <= PH_HOLD;
            end
          end
          default: begin
            if (!stall) m_phase[i] <= PH_IDLE;
          end
        endcase
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(posedge clk) begin
    #2;
    chk("m_done",   64'(done),     64'(m_phase[0] == PH_HOLD));
    chk("m_busy",   64'(busy),     64'(m_phase[0] == PH_WORK));
    chk("m_result", result,        m_res[0]);
    chk("f_done",   64'(done_f),   64'(m_phase[1] == PH_HOLD));
    chk("f_busy",   64'(busy_f),   64'(m_phase[1] == PH_WORK));
    chk("f_result", result_f,      m_res[1]);
  end

  // Count negedges until done (bounded), noting the fast instance's first done.
  task automatic wait_done(output int n, output int nf, output logic [63:0] rf);
    n  = 0;
    nf = -1;
    rf = 64'h0;
    do begin
      @(negedge clk);
      n++;
      if (nf < 0 && done_f) begin
        nf = n;
        rf = result_f;
      end
    end while (!done && n < 100);
  endtask

  // Present an op at this negedge with the unit idle; check latency and value.
  task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input string name, input int exp_flat);
    int n, nf;
    logic [63:0] rf;
    funct = f;
    op1   = a;
    op2   = b;
    wait_done(n, nf, rf);
    chk({name, "_lat"},  64'(n),  64'(33));
    chk({name, "_res"},  result,  exp);
    chk({name, "_flat"}, 64'(nf), 64'(exp_flat));
    chk({name, "_fres"}, rf,      exp);
    funct = 6'h0;
    @(negedge clk);
  endtask

  initial begin
    int n, nf;
    logic [63:0] rf;
    rst   = 1'b1;
    flush = 1'b0;
    stall = 1'b0;
    funct = 6'h0;
    op1   = 32'h0;
    op2   = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_done",   64'(done), 64'h0);
    chk("rst_busy",   64'(busy), 64'h0);
    chk("rst_result", result,    64'h0);
    rst = 1'b0;
    @(negedge clk);

    do_op(F_MULT,  32'hFFFFFFFD, 32'd5,        64'hFFFFFFFF_FFFFFFF1, "mult_neg", 1);
    do_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, "multu_max", 1);
    do_op(F_DIV,   32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, "div_neg", 33);
    do_op(F_DIVU,  32'd7,        32'd0,        64'h00000007_FFFFFFFF, "divu_zero", 33);
    do_op(F_DIV,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, "div_ovf", 33);
    do_op(F_DIV,   32'h80000000, 32'h0,        64'h80000000_FFFFFFFF, "div_zero_neg", 33);

    // Held in DONE by stall, then a back-to-back divide.
    funct = F_DIVU;
    op1   = 32'd100;
    op2   = 32'd7;
    wait_done(n, nf, rf);
    chk("stall_lat", 64'(n), 64'(33));
    chk("stall_res", result, 64'h00000002_0000000E);
    stall = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_hold_done", 64'(done), 64'h1);
      chk("stall_hold_busy", 64'(busy), 64'h0);
      chk("stall_hold_res",  result,    64'h00000002_0000000E);
    end
    stall = 1'b0;
    op1   = 32'd9;
    op2   = 32'd3;
    @(negedge clk);
    chk("b2b_idle_done", 64'(done), 64'h0);
    chk("b2b_idle_busy", 64'(busy), 64'h0);
    wait_done(n, nf, rf);
    chk("b2b_lat", 64'(n), 64'(33));
    chk("b2b_res", result, 64'h00000000_00000003);
    funct = 6'h0;
    @(negedge clk);

    // Flush while busy at iteration 10.
    funct = F_DIV;
    op1   = 32'd1000;
    op2   = 32'd3;
    repeat (11) @(negedge clk);
    chk("flush_pre_busy", 64'(busy), 64'h1);
    flush = 1'b1;
    funct = 6'h0;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_done", 64'(done), 64'h0);
    chk("flush_busy", 64'(busy), 64'h0);
    chk("flush_res",  result,    64'h00000000_00000003);
    repeat (40) @(negedge clk);
    chk("flush_late_done", 64'(done), 64'h0);
    chk("flush_late_res",  result,    64'h00000000_00000003);

    // Asynchronous reset mid-operation.
    funct = F_MULT;
    op1   = 32'd7;
    op2   = 32'd9;
    repeat (5) @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_done",   64'(done), 64'h0);
    chk("arst_busy",   64'(busy), 64'h0);
    chk("arst_result", result,    64'h0);
    @(negedge clk);
    rst   = 1'b0;
    funct = 6'h0;
    @(negedge clk);
    do_op(F_MULT, 32'd2, 32'd3, 64'h00000000_00000006, "mult_after_rst", 1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
